// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// The optional burst lock is enabled by defining RR_MUX_LOCK_EN.
package rr_mux_pkg;

  // Output stage state: IDLE means no word held, BUSY means out is valid.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Default requester count and the matching pointer width.
  localparam int unsigned N_DEFAULT   = 4;
  localparam int unsigned IDX_W       = $clog2(N_DEFAULT);

  // Upper bound on requester count supported by the one-hot helper.
  localparam int unsigned MAX_N       = 64;
  localparam int unsigned MAX_IDX_W   = $clog2(MAX_N);

  // Pointer / index width for an arbitrary requester count.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // One-hot decode of an index; callers cast down to their own lane count.
  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_N-1:0] one;
    one = {{(MAX_N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage : rr_mux_pkg

// File: rtl/rr_mux_arbiter_if.sv
// Bus bundle between the requesters/downstream (master) and the arbiter (slave).
// The lock vector only exists when RR_MUX_LOCK_EN is defined.
//
// Handshake: out carries a word whenever out_valid is high; the word is
// consumed at a rising edge where out_valid && out_ready. out and out_valid
// hold unchanged while out_valid && !out_ready. A requester raises req[i]
// with its word stable on lane i and keeps both until the edge at which
// grant[i] is high; req still high after that edge is a fresh request.
interface rr_mux_arbiter_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 4
);
  logic [N*WIDTH-1:0] in;
  logic [N-1:0]       req;
`ifdef RR_MUX_LOCK_EN
  logic [N-1:0]       lock;
`endif
  logic               out_ready;
  logic [N-1:0]       grant;
  logic [WIDTH-1:0]   out;
  logic               out_valid;

  modport master (
    output in,
    output req,
`ifdef RR_MUX_LOCK_EN
    output lock,
`endif
    output out_ready,
    input  grant,
    input  out,
    input  out_valid
  );

  modport slave (
    input  in,
    input  req,
`ifdef RR_MUX_LOCK_EN
    input  lock,
`endif
    input  out_ready,
    output grant,
    output out,
    output out_valid
  );
endinterface : rr_mux_arbiter_if

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating priority encoder: finds the first requesting lane starting at
// ptr_i and wrapping modulo N. Purely combinational.
module rr_priority_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        idx_o   = IW'((int'(ptr_i) + k) % N);
        found_o = 1'b1;
      end
    end
  end

endmodule : rr_priority_pick

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with a registered valid/ready output stage that shares
// one WIDTH-bit channel among N requesters. Define RR_MUX_LOCK_EN to add the
// per-lane burst lock that keeps priority on the winning lane.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter int unsigned     N       = 4,
  parameter logic [WIDTH-1:0] DEFAULT = {WIDTH{1'b0}}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  rr_mux_arbiter_if.slave                bus,
  output state_t                         dbg_state_o,
  output logic [idx_width(N)-1:0]        dbg_ptr_o
);

  localparam int unsigned IW = idx_width(N);

  state_t           state_q;
  logic [WIDTH-1:0] out_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_d;

  logic [IW-1:0]    win_idx;
  logic             win_found;
  logic             free;
  logic             capture;
  logic [N-1:0]     grant_d;
  logic [WIDTH-1:0] win_word;

  rr_priority_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  // Decide whether this edge captures, which lane, and where priority moves.
  always_comb begin
    free     = (state_q == IDLE) || bus.out_ready;
    capture  = rst_n && free && win_found;
    win_word = bus.in[int'(win_idx)*WIDTH +: WIDTH];
    grant_d  = '0;
    ptr_d    = ptr_q;
    if (capture) begin
      grant_d = N'(onehot(MAX_IDX_W'(win_idx)));
      ptr_d   = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
`ifdef RR_MUX_LOCK_EN
      // A locked winner keeps top priority for its next beat.
      if (bus.lock[win_idx]) begin
        ptr_d = win_idx;
      end
`endif
    end
  end

  // Output stage FSM: holds the captured word until accepted, refills on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= DEFAULT;
      ptr_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      case (state_q)
        IDLE: begin
          if (capture) begin
            state_q <= BUSY;
            out_q   <= win_word;
          end else begin
            out_q   <= DEFAULT;
          end
        end
        BUSY: begin
          if (capture) begin
            out_q   <= win_word;
          end else if (bus.out_ready) begin
            state_q <= IDLE;
            out_q   <= DEFAULT;
          end
        end
        default: begin
          state_q <= IDLE;
          out_q   <= DEFAULT;
        end
      endcase
    end
  end

  assign bus.grant     = grant_d;
  assign bus.out       = out_q;
  assign bus.out_valid = (state_q == BUSY);
  assign dbg_state_o   = state_q;
  assign dbg_ptr_o     = ptr_q;

endmodule : rr_mux_arbiter

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus random
// traffic, all compared against a behavioural round-robin model.
module tb_rr_mux_arbiter;
  import rr_mux_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned N = 4;
  localparam logic [W-1:0] DEF = '0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  state_t     dbg_state;
  logic [1:0] dbg_ptr;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int             m_ptr;
  int             m_valid;
  logic [W-1:0]   m_out;

  rr_mux_arbiter_if #(.WIDTH(W), .N(N)) bus ();

  rr_mux_arbiter #(
    .WIDTH   (W),
    .N       (N),
    .DEFAULT (DEF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 0;
    m_out   = DEF;
  endtask

  // Drive one cycle of stimulus, check grant before the edge and the
  // registered outputs just after it.
  task automatic step(input logic [N-1:0] r, input logic rdy,
                      input logic [N-1:0] lk, input logic [N*W-1:0] data);
    int   win;
    int   n_ptr;
    int   n_valid;
    logic [W-1:0] n_out;
    logic [N-1:0] e_grant;
    @(negedge clk);
    bus.req       = r;
    bus.out_ready = rdy;
    bus.in        = data;
`ifdef RR_MUX_LOCK_EN
    bus.lock      = lk;
`endif
    e_grant = '0;
    n_ptr   = m_ptr;
    n_valid = m_valid;
    n_out   = m_out;
    if (m_valid == 0 || rdy) begin
      win = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && r[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      if (win >= 0) begin
        e_grant = N'(1) << win;
        n_out   = W'(data >> (win * W));
        n_valid = 1;
        n_ptr   = (win + 1) % N;
`ifdef RR_MUX_LOCK_EN
        if (lk[win]) n_ptr = win;
`endif
      end else begin
        n_out   = DEF;
        n_valid = 0;
      end
    end
    #1;
    check("grant", 32'(bus.grant), 32'(e_grant));
    @(posedge clk);
    m_ptr   = n_ptr;
    m_valid = n_valid;
    m_out   = n_out;
    #1;
    check("out", 32'(bus.out), 32'(m_out));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("ptr", 32'(dbg_ptr), 32'(m_ptr));
    check("state", 32'(dbg_state), (m_valid != 0) ? 32'(BUSY) : 32'(IDLE));
  endtask

  localparam logic [N*W-1:0] ABCD = 16'hABCD;

  initial begin
    logic [N-1:0] lk0;
    lk0 = '0;
    bus.req = '0;
    bus.out_ready = 1'b0;
    bus.in = ABCD;
`ifdef RR_MUX_LOCK_EN
    bus.lock = '0;
`endif
    model_reset();

    // Reset values
    #12;
    check("rst_out", 32'(bus.out), 32'(DEF));
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ptr", 32'(dbg_ptr), 32'd0);
    bus.req = 4'b1111;
    #1;
    check("rst_grant", 32'(bus.grant), 32'd0);
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, then wrap of the pointer
    step(4'b0010, 1'b1, lk0, ABCD);
    check("tp_out_c", 32'(bus.out), 32'hC);
    check("tp_ptr2", 32'(dbg_ptr), 32'd2);
    step(4'b1001, 1'b1, lk0, ABCD);
    check("tp_out_a", 32'(bus.out), 32'hA);
    step(4'b1001, 1'b1, lk0, ABCD);
    check("tp_out_d", 32'(bus.out), 32'hD);

    // Stall for three cycles, then release
    repeat (3) step(4'b0100, 1'b0, lk0, ABCD);
    check("tp_stall_out", 32'(bus.out), 32'hD);
    step(4'b0100, 1'b1, lk0, ABCD);
    check("tp_out_b", 32'(bus.out), 32'hB);

    // Full contention, eight captures
    repeat (8) step(4'b1111, 1'b1, lk0, ABCD);

    // Drain to idle
    step(4'b0000, 1'b1, lk0, ABCD);
    check("tp_idle_out", 32'(bus.out), 32'(DEF));

    // Reset mid-stream
    step(4'b1111, 1'b1, lk0, ABCD);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(bus.out), 32'(DEF));
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_grant", 32'(bus.grant), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_ptr", 32'(dbg_ptr), 32'd0);

`ifdef RR_MUX_LOCK_EN
    // Burst lock on lane 1, then release
    repeat (3) step(4'b1111, 1'b1, 4'b0010, ABCD);
    check("lock_ptr", 32'(dbg_ptr), 32'd1);
    step(4'b1111, 1'b1, 4'b0000, ABCD);
    step(4'b1111, 1'b1, 4'b0000, ABCD);
    check("unlock_out_b", 32'(bus.out), 32'hB);
`endif

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      step(N'($urandom_range(0, (1 << N) - 1)),
           ($urandom_range(0, 3) != 0),
           N'($urandom_range(0, (1 << N) - 1)),
           (N*W)'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rr_mux_arbiter
